// File: rtl/branch_pkg.sv
// Shared encodings for the comparator interface and the branch resolver.
// The comparator and the resolver both import this package, so every
// encoding lives in one place.
package branch_pkg;

    // Comparator result encodings (in1 relative to in2)
    localparam logic [1:0] CMP_EQ  = 2'b00;
    localparam logic [1:0] CMP_GT  = 2'b01;
    localparam logic [1:0] CMP_LT  = 2'b10;
    localparam logic [1:0] CMP_BAD = 2'b11;

    // Branch opcode encodings
    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BLT = 2'b01;
    localparam logic [1:0] BR_BGT = 2'b10;
    localparam logic [1:0] BR_BNE = 2'b11;

    // Resolver control states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RESOLVE = 2'b01,
        ST_FLUSH   = 2'b10
    } state_t;

    // Branch direction from opcode and comparator result; an illegal
    // comparator result never matches any condition, so it falls through.
    function automatic logic branch_taken(input logic [1:0] op, input logic [1:0] cmp);
        logic result;
        result = 1'b0;
        case (op)
            BR_BEQ:  result = (cmp == CMP_EQ);
            BR_BLT:  result = (cmp == CMP_LT);
            BR_BGT:  result = (cmp == CMP_GT);
            BR_BNE:  result = (cmp == CMP_GT) || (cmp == CMP_LT);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Branch target arithmetic: fall-through address and the taken target
// (pc + 2 + sign-extended word offset * 2). All sums wrap modulo 2^PC_W.
module branch_target_adder #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  fall_through,
    output logic [PC_W-1:0]  taken_target
);

    logic [PC_W-1:0] offset_ext;

    // Offset is a signed word count; widen to PC width before scaling to bytes
    assign offset_ext   = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    assign fall_through = pc + PC_W'(2);
    assign taken_target = fall_through + (offset_ext << 1);

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver. Accepts a branch request with the
// comparator result, answers one cycle later with direction and next PC,
// then holds the front-end flush for FLUSH_CYCLES after a taken branch.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int OFF_W        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       br_op,
    input  logic [1:0]       cmp_result,
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] offset,
    output logic             resp_valid,
    output logic             taken,
    output logic [PC_W-1:0]  target_pc,
    output logic             flush,
    output logic             cmp_err
);

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      flush_cnt;
    logic [3:0]      flush_cnt_nxt;
    logic            accept;
    logic            decide_taken;
    logic [PC_W-1:0] fall_through;
    logic [PC_W-1:0] taken_target;

    branch_target_adder #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_adder (
        .pc           (pc),
        .offset       (offset),
        .fall_through (fall_through),
        .taken_target (taken_target)
    );

    assign accept       = req_valid && req_ready;
    assign decide_taken = branch_taken(br_op, cmp_result);

    // State and flush-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            flush_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Next-state logic and state-decoded handshake/pulse outputs
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        flush         = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                resp_valid = 1'b1;
                if (taken) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = 4'(FLUSH_CYCLES - 1);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (flush_cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    flush_cnt_nxt = flush_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the decision at accept; it is presented in RESOLVE and held until the next response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken     <= 1'b0;
            target_pc <= '0;
            cmp_err   <= 1'b0;
        end else if (accept) begin
            taken     <= decide_taken;
            target_pc <= decide_taken ? taken_target : fall_through;
            cmp_err   <= (cmp_result == CMP_BAD);
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed vector table,
// hand-written multi-cycle sequences, and randomized requests against a
// behavioural model.
module tb_branch_resolver;

    localparam int PC_W         = 16;
    localparam int OFF_W        = 8;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  br_op = 2'b00;
    logic [1:0]  cmp_result = 2'b00;
    logic [15:0] pc = 16'h0000;
    logic [7:0]  offset = 8'h00;
    logic        resp_valid;
    logic        taken;
    logic [15:0] target_pc;
    logic        flush;
    logic        cmp_err;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  cmp;
        logic [15:0] pc;
        logic [7:0]  off;
        logic        exp_taken;
        logic [15:0] exp_target;
        logic        exp_err;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    branch_resolver #(
        .PC_W         (PC_W),
        .OFF_W        (OFF_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .br_op      (br_op),
        .cmp_result (cmp_result),
        .pc         (pc),
        .offset     (offset),
        .resp_valid (resp_valid),
        .taken      (taken),
        .target_pc  (target_pc),
        .flush      (flush),
        .cmp_err    (cmp_err)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // Reference model straight from the decision and target rules
    function automatic void model(input logic [1:0] op, input logic [1:0] cmp,
                                  input logic [15:0] pcv, input logic [7:0] off,
                                  output logic t, output logic [15:0] tgt, output logic e);
        int so;
        int addr;
        e = (cmp == 2'b11);
        case (op)
            2'b00:   t = (cmp == 2'b00);
            2'b01:   t = (cmp == 2'b10);
            2'b10:   t = (cmp == 2'b01);
            default: t = (cmp == 2'b01) || (cmp == 2'b10);
        endcase
        so = int'(off);
        if (so >= 128) so = so - 256;
        addr = int'(pcv) + 2;
        if (t) addr = addr + so * 2;
        tgt = addr[15:0];
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [1:0] cmp,
                                 input logic [15:0] pcv, input logic [7:0] off);
        br_op      = op;
        cmp_result = cmp;
        pc         = pcv;
        offset     = off;
        req_valid  = 1'b1;
    endtask

    task automatic scrambleInputs();
        br_op      = 2'($urandom);
        cmp_result = 2'($urandom);
        pc         = 16'($urandom);
        offset     = 8'($urandom);
    endtask

    // Full request from IDLE back to IDLE; called and returns just after a negedge
    task automatic runRequest(input string name, input logic [1:0] op, input logic [1:0] cmp,
                              input logic [15:0] pcv, input logic [7:0] off,
                              input logic et, input logic [15:0] etgt, input logic ee);
        checkFlag({name, " ready_before"}, req_ready, 1'b1);
        applyStimulus(op, cmp, pcv, off);
        @(negedge clk);
        req_valid = 1'b0;
        scrambleInputs();
        checkFlag({name, " resp_valid"}, resp_valid, 1'b1);
        checkFlag({name, " taken"}, taken, et);
        checkOutput({name, " target"}, target_pc, etgt);
        checkFlag({name, " cmp_err"}, cmp_err, ee);
        checkFlag({name, " flush_in_resolve"}, flush, 1'b0);
        checkFlag({name, " ready_in_resolve"}, req_ready, 1'b0);
        if (et) begin
            for (int i = 0; i < FLUSH_CYCLES; i++) begin
                @(negedge clk);
                checkFlag($sformatf("%s flush[%0d]", name, i), flush, 1'b1);
                checkFlag($sformatf("%s ready_in_flush[%0d]", name, i), req_ready, 1'b0);
                checkFlag($sformatf("%s resp_in_flush[%0d]", name, i), resp_valid, 1'b0);
                checkOutput($sformatf("%s target_hold[%0d]", name, i), target_pc, etgt);
            end
        end
        @(negedge clk);
        checkFlag({name, " ready_after"}, req_ready, 1'b1);
        checkFlag({name, " flush_after"}, flush, 1'b0);
        checkFlag({name, " resp_after"}, resp_valid, 1'b0);
        checkFlag({name, " taken_hold"}, taken, et);
        checkOutput({name, " target_hold"}, target_pc, etgt);
        checkFlag({name, " err_hold"}, cmp_err, ee);
    endtask

    task automatic checkResetOutputs(input string name);
        checkFlag({name, " req_ready"}, req_ready, 1'b1);
        checkFlag({name, " resp_valid"}, resp_valid, 1'b0);
        checkFlag({name, " taken"}, taken, 1'b0);
        checkOutput({name, " target"}, target_pc, 16'h0000);
        checkFlag({name, " flush"}, flush, 1'b0);
        checkFlag({name, " cmp_err"}, cmp_err, 1'b0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        mt;
        logic [15:0] mtgt;
        logic        me;
        logic [1:0]  rop;
        logic [1:0]  rcmp;
        logic [15:0] rpc;
        logic [7:0]  roff;

        vecs[0] = '{2'b00, 2'b00, 16'h0010, 8'h04, 1'b1, 16'h001A, 1'b0};
        vecs[1] = '{2'b00, 2'b00, 16'hFFFE, 8'h01, 1'b1, 16'h0002, 1'b0};
        vecs[2] = '{2'b01, 2'b01, 16'h0100, 8'hF0, 1'b0, 16'h0102, 1'b0};
        vecs[3] = '{2'b10, 2'b01, 16'h0100, 8'hFC, 1'b1, 16'h00FA, 1'b0};
        vecs[4] = '{2'b11, 2'b10, 16'h0020, 8'h02, 1'b1, 16'h0026, 1'b0};
        vecs[5] = '{2'b00, 2'b11, 16'h0040, 8'h05, 1'b0, 16'h0042, 1'b1};
        vecs[6] = '{2'b11, 2'b11, 16'h0300, 8'h10, 1'b0, 16'h0302, 1'b1};
        vecs[7] = '{2'b01, 2'b10, 16'h1000, 8'h80, 1'b1, 16'h0F02, 1'b0};
        vecs[8] = '{2'b10, 2'b00, 16'h0200, 8'h7F, 1'b0, 16'h0202, 1'b0};
        vecs[9] = '{2'b11, 2'b00, 16'hFFFF, 8'h7F, 1'b0, 16'h0001, 1'b0};

        #2;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            runRequest($sformatf("vec%0d", i), vecs[i].op, vecs[i].cmp, vecs[i].pc, vecs[i].off,
                       vecs[i].exp_taken, vecs[i].exp_target, vecs[i].exp_err);
        end

        // Not-taken back-to-back: second request held on req_valid through RESOLVE
        applyStimulus(2'b01, 2'b01, 16'h0100, 8'hF0);
        @(negedge clk);
        applyStimulus(2'b10, 2'b01, 16'h0100, 8'hFC);
        checkFlag("b2b_nt first resp", resp_valid, 1'b1);
        checkOutput("b2b_nt first target", target_pc, 16'h0102);
        @(negedge clk);
        checkFlag("b2b_nt ready after resolve", req_ready, 1'b1);
        checkFlag("b2b_nt no resp in gap", resp_valid, 1'b0);
        checkFlag("b2b_nt no flush", flush, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        checkFlag("b2b_nt second resp", resp_valid, 1'b1);
        checkFlag("b2b_nt second taken", taken, 1'b1);
        checkOutput("b2b_nt second target", target_pc, 16'h00FA);
        repeat (FLUSH_CYCLES + 1) @(negedge clk);
        checkFlag("b2b_nt idle", req_ready, 1'b1);

        // Taken back-to-back: req_ready low for RESOLVE plus the flush window
        applyStimulus(2'b00, 2'b00, 16'h0010, 8'h04);
        @(negedge clk);
        applyStimulus(2'b11, 2'b10, 16'h0020, 8'h02);
        checkFlag("b2b_t first resp", resp_valid, 1'b1);
        checkOutput("b2b_t first target", target_pc, 16'h001A);
        checkFlag("b2b_t ready low resolve", req_ready, 1'b0);
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            @(negedge clk);
            checkFlag($sformatf("b2b_t flush[%0d]", i), flush, 1'b1);
            checkFlag($sformatf("b2b_t ready low[%0d]", i), req_ready, 1'b0);
            checkFlag($sformatf("b2b_t no resp[%0d]", i), resp_valid, 1'b0);
        end
        @(negedge clk);
        checkFlag("b2b_t ready after flush", req_ready, 1'b1);
        checkFlag("b2b_t flush done", flush, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        checkFlag("b2b_t second resp", resp_valid, 1'b1);
        checkOutput("b2b_t second target", target_pc, 16'h0026);
        repeat (FLUSH_CYCLES + 1) @(negedge clk);
        checkFlag("b2b_t idle", req_ready, 1'b1);

        // Reset in the middle of FLUSH
        applyStimulus(2'b00, 2'b00, 16'h0010, 8'h04);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checkFlag("rst_flush pre flush", flush, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_flush");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkFlag($sformatf("rst_flush post resp[%0d]", i), resp_valid, 1'b0);
            checkFlag($sformatf("rst_flush post ready[%0d]", i), req_ready, 1'b1);
            checkFlag($sformatf("rst_flush post flush[%0d]", i), flush, 1'b0);
        end

        // Reset during RESOLVE aborts the response
        applyStimulus(2'b11, 2'b01, 16'h0500, 8'h03);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_resolve");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkFlag($sformatf("rst_resolve post resp[%0d]", i), resp_valid, 1'b0);
            checkFlag($sformatf("rst_resolve post flush[%0d]", i), flush, 1'b0);
        end

        // Randomized requests against the model
        for (int i = 0; i < 300; i++) begin
            rop  = 2'($urandom);
            rcmp = 2'($urandom);
            rpc  = 16'($urandom);
            roff = 8'($urandom);
            model(rop, rcmp, rpc, roff, mt, mtgt, me);
            runRequest($sformatf("rand%0d", i), rop, rcmp, rpc, roff, mt, mtgt, me);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
